// File: rtl/prog_loader.sv
// prog_loader: receives a program image as a byte stream and writes it into
// instruction memory while holding the CPU datapath in reset.
//
// Stream: 16-bit word count N (high byte first), then N big-endian 32-bit words.
//
// Ports
//   clk          rising-edge system clock
//   reset        synchronous active-low reset
//   start        one-cycle request to begin a load (honoured in IDLE/DONE/ERR)
//   in_byte      incoming stream byte
//   in_valid     in_byte is valid
//   in_ready     loader accepts a byte this cycle
//   mem_we       instruction-memory write strobe (one cycle per word)
//   mem_addr     instruction-memory word address
//   mem_wdata    instruction word being written
//   cpu_hold     datapath held in reset while high (low only in DONE)
//   done         load completed successfully
//   error        declared length exceeded DEPTH
//   words_loaded words written in the current load
module prog_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR} state_t;

    state_t      state;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;     // first three bytes of the word being assembled

    logic            xfer;
    logic [15:0]     len_new;
    logic [ADDR_W:0] wl_next;

    assign xfer    = in_valid & in_ready;
    assign len_new = {len_hi, in_byte};
    assign wl_next = words_loaded + {{ADDR_W{1'b0}}, 1'b1};

    // All outputs are registered; in_ready is updated together with the state
    // so it always reflects the state the FSM is in.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            len_hi       <= '0;
            len          <= '0;
            byte_cnt     <= '0;
            shift        <= '0;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= LEN_HI;
                        in_ready     <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        byte_cnt     <= '0;
                        mem_addr     <= '0;
                        words_loaded <= '0;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_hi <= in_byte;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len <= len_new;
                        if (len_new == 16'd0) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (32'(len_new) > 32'(DEPTH)) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        shift    <= {shift[15:0], in_byte};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // 4th byte: strobe the write in the very next cycle
                            state     <= WRITE;
                            in_ready  <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_wdata <= {shift, in_byte};
                        end
                    end
                end
                WRITE: begin
                    mem_we       <= 1'b0;
                    // wraps to 0 after the DEPTH-th word; unused from then on
                    mem_addr     <= mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    words_loaded <= wl_next;
                    if (32'(wl_next) == 32'(len)) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state    <= DATA;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    mem_we   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: expected writes go into a scoreboard
// queue as the 4th byte of each word is accepted, and are popped and compared
// (address, data, cycle) whenever mem_we is seen.
module tb_prog_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .in_byte(in_byte),
        .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t q[$];
    int  errs = 0;
    int  checks = 0;
    int  cyc = 0;
    int  last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // scoreboard consumer
    always @(negedge clk) begin
        if (reset === 1'b1 && mem_we === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_write", 64'(mem_addr), 64'hFFFF);
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(e.addr));
                chk("wr_data", 64'(mem_wdata), 64'(e.data));
                chk("wr_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last_acc = cyc;
    endtask

    task automatic send_word(input int addr, input logic [31:0] w, input int gap);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) send_byte(v[31-8*i -: 8], gap);
        q.push_back('{addr: addr, data: w, cyc: last_acc});
    endtask

    task automatic send_len(input int n);
        logic [15:0] v;
        v = 16'(n);
        send_byte(v[15:8], 0);
        send_byte(v[7:0], 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic d, input logic e,
                                input logic h, input int wl);
        repeat (2) @(negedge clk);
        chk({tag, "_done"}, 64'(done), 64'(d));
        chk({tag, "_error"}, 64'(error), 64'(e));
        chk({tag, "_hold"}, 64'(cpu_hold), 64'(h));
        chk({tag, "_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_words"}, 64'(words_loaded), 64'(wl));
        chk({tag, "_sb_empty"}, 64'(q.size()), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_hold"}, 64'(cpu_hold), 64'd1);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_words"}, 64'(words_loaded), 64'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", 64'(in_ready), 64'd0);

        // two-word program
        pulse_start();
        chk("lenhi_ready", 64'(in_ready), 64'd1);
        send_len(2);
        send_word(0, 32'h20080005, 0);
        send_word(1, 32'hAC080010, 0);
        check_status("two", 1'b1, 1'b0, 1'b0, 2);
        chk("two_last_addr", 64'(mem_addr), 64'd2);
        chk("two_wdata_hold", 64'(mem_wdata), 64'hAC080010);

        // empty program
        pulse_start();
        chk("restart_done_clr", 64'(done), 64'd0);
        send_len(0);
        check_status("empty", 1'b1, 1'b0, 1'b0, 0);

        // oversize length
        pulse_start();
        send_len(257);
        check_status("oversize", 1'b0, 1'b1, 1'b1, 0);
        pulse_start();
        chk("err_restart_error", 64'(error), 64'd0);
        chk("err_restart_ready", 64'(in_ready), 64'd1);

        // N=1 with stalls: valid pattern 1-0-0-1-0-1-1
        send_len(1);
        send_word(0, 32'h12345678, 0);
        check_status("nogap_ref", 1'b1, 1'b0, 1'b0, 1);
        pulse_start();
        send_len(1);
        send_byte(8'h12, 0);
        send_byte(8'h34, 2);
        send_byte(8'h56, 1);
        send_byte(8'h78, 0);
        q.push_back('{addr: 0, data: 32'h12345678, cyc: last_acc});
        check_status("stall", 1'b1, 1'b0, 1'b0, 1);

        // reset mid-word
        pulse_start();
        send_len(1);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("midreset");
        reset = 1'b1;
        pulse_start();
        send_len(1);
        send_word(0, 32'hCAFEF00D, 0);
        check_status("after_reset", 1'b1, 1'b0, 1'b0, 1);

        // start during DATA is ignored
        pulse_start();
        send_len(2);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        pulse_start();
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        q.push_back('{addr: 0, data: 32'h11223344, cyc: last_acc});
        send_word(1, 32'h55667788, 0);
        check_status("start_in_data", 1'b1, 1'b0, 1'b0, 2);

        // full depth
        pulse_start();
        send_len(DEPTH);
        for (int i = 0; i < DEPTH; i++) send_word(i, 32'(i) * 32'h01010101 ^ 32'hA5000000, 0);
        check_status("full", 1'b1, 1'b0, 1'b0, DEPTH);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        chk("global_timeout", 64'd1, 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8, width of the instruction-memory word address.
REQ-002 Parameter DEPTH, default 256, number of writable instruction words (DEPTH <= 2**ADDR_W).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Port: clk  input  1  rising-edge system clock.
REQ-005 Port: reset  input  1  synchronous active-low reset.
REQ-006 Port: start  input  1  one-cycle request to begin a program load.
REQ-007 Port: in_byte  input  8  incoming program stream byte.
REQ-008 Port: in_valid  input  1  in_byte holds a valid byte.
REQ-009 Port: in_ready  output  1  loader accepts a byte this cycle.
REQ-010 Port: mem_we  output  1  instruction-memory write strobe.
REQ-011 Port: mem_addr  output  ADDR_W  instruction-memory word address.
REQ-012 Port: mem_wdata  output  32  instruction word to write.
REQ-013 Port: cpu_hold  output  1  holds the datapath in reset while high.
REQ-014 Port: done  output  1  load completed successfully.
REQ-015 Port: error  output  1  declared length exceeded DEPTH.
REQ-016 Port: words_loaded  output  ADDR_W+1  count of words written in the current load.

Function
REQ-017 The stream format SHALL be: 16-bit word count N (high byte first), then 4*N bytes, with each word big-endian (first byte goes to mem_wdata[31:24]).
REQ-018 A byte SHALL be transferred only on a rising clk edge where in_valid=1 and in_ready=1.
REQ-019 The state machine SHALL have the states IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE and ERR.
REQ-020 IDLE: in_ready=0; start=1 -> LEN_HI; words_loaded, the byte counter and mem_addr SHALL clear to 0.
REQ-021 LEN_HI / LEN_LO: in_ready=1; each state captures one length byte and advances on transfer.
REQ-022 After LEN_LO, the next state SHALL be DONE if N=0, ERR if N>DEPTH, otherwise DATA.
REQ-023 DATA: in_ready=1; bytes shift into a 32-bit assembly register; the 4th transfer moves the FSM to WRITE.
REQ-024 WRITE: in_ready=0; mem_we=1 for exactly one cycle with mem_addr = current word index and mem_wdata = the assembled word.
REQ-025 On leaving WRITE, mem_addr and words_loaded SHALL increment by 1; the next state is DONE if words_loaded reaches N, else DATA.
REQ-026 Byte-to-write latency SHALL be exactly 1 cycle: mem_we is asserted in the cycle after the 4th byte is accepted.
REQ-027 mem_we SHALL be 0 in every state except WRITE; mem_addr and mem_wdata SHALL hold their last value when mem_we=0.
REQ-028 DONE: done=1, cpu_hold=0, in_ready=0.
REQ-029 ERR: error=1, cpu_hold=1, in_ready=0, and no memory writes occur.
REQ-030 cpu_hold SHALL be 1 in every state other than DONE.
REQ-031 start SHALL be ignored in LEN_HI, LEN_LO, DATA and WRITE.
REQ-032 In DONE or ERR, start SHALL behave as in IDLE: clear done, error, the counters and mem_addr, then go to LEN_HI.
REQ-033 N=DEPTH SHALL be accepted; the last write goes to address DEPTH-1, and mem_addr is not used after the wrap.
REQ-034 in_valid gaps (stalls) SHALL be tolerated in any receiving state with no loss or duplication of bytes.

Reset
REQ-035 While reset=0 at a clk edge, the block SHALL enter IDLE.
REQ-036 Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0.
REQ-037 Reset asserted mid-load SHALL abort the load with no further mem_we, and apply the REQ-036 values on the next edge.

Verification
REQ-038 start, then bytes 00 02 | 20 08 00 05 | AC 08 00 10 -> writes (0,0x20080005) and (1,0xAC080010), each mem_we one cycle after the 4th byte; then done=1, cpu_hold=0, words_loaded=2.
REQ-039 start, then bytes 00 00 -> DONE directly, zero writes, done=1, cpu_hold=0.
REQ-040 start, then bytes 01 01 (N=257 > 256) -> error=1, in_ready=0, cpu_hold=1, no writes; a following start restarts to LEN_HI with error=0.
REQ-041 N=1 with in_valid toggling 1-0-0-1-0-1-1 across the bytes 12 34 56 78 -> single write 0x12345678 at address 0 and no duplicate bytes.
REQ-042 reset=0 asserted after 2 of 4 data bytes -> all outputs at REQ-036 values, no write; a fresh load then writes from address 0.
REQ-043 start pulsed during DATA -> ignored; the load completes unchanged.
